// File: rtl/matmul_job_arbiter.sv
// matmul_job_arbiter: round-robin sharing of one sequential matrix multiplier between two requesters
// Ports: req*/gnt*/done*/err* per requester; a_in*/b_in* muxed to m_a_in/m_b_in; indices and results
// broadcast (z_stb*/z_ack* routed to owner); m_* drive and observe the multiplier; jobs_done counts jobs.
module matmul_job_arbiter #(
  parameter int M = 4,
  parameter int DW = 32,
  parameter int IW = $clog2(M),
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  input  logic [DW-1:0] a_in0,
  input  logic [DW-1:0] b_in0,
  input  logic [DW-1:0] a_in1,
  input  logic [DW-1:0] b_in1,
  output logic [IW-1:0] a_i,
  output logic [IW-1:0] a_j,
  output logic [IW-1:0] b_i,
  output logic [IW-1:0] b_j,
  output logic [DW-1:0] z_out,
  output logic [IW-1:0] z_i,
  output logic [IW-1:0] z_j,
  output logic          z_stb0,
  output logic          z_stb1,
  input  logic          z_ack0,
  input  logic          z_ack1,
  output logic          m_rst,
  output logic          m_start,
  output logic [DW-1:0] m_a_in,
  output logic [DW-1:0] m_b_in,
  input  logic [IW-1:0] m_a_i,
  input  logic [IW-1:0] m_a_j,
  input  logic [IW-1:0] m_b_i,
  input  logic [IW-1:0] m_b_j,
  input  logic [DW-1:0] m_z_out,
  input  logic [IW-1:0] m_z_i,
  input  logic [IW-1:0] m_z_j,
  input  logic          m_z_stb,
  output logic          m_z_ack,
  input  logic          m_done,
  output logic [15:0]   jobs_done
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} state_t;
  state_t r_state, w_next;
  logic r_own, r_ptr;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_jobs;
  logic w_req_own, w_run, w_to, w_kill, w_any;
  assign a_i = m_a_i;
  assign a_j = m_a_j;
  assign b_i = m_b_i;
  assign b_j = m_b_j;
  assign z_out = m_z_out;
  assign z_i = m_z_i;
  assign z_j = m_z_j;
  assign m_a_in = r_own ? a_in1 : a_in0;
  assign m_b_in = r_own ? b_in1 : b_in0;
  assign jobs_done = r_jobs;
  always_comb begin
    w_any = req0 || req1;
    w_req_own = r_own ? req1 : req0;
    w_run = r_state == RUN;
    w_to = w_run && r_cnt == CW'(TIMEOUT - 1);
    // owner dropping req or a timeout tears the job down; this beats m_done
    w_kill = w_run && (!w_req_own || w_to);
    w_next = r_state == IDLE ? (w_any ? CLEAR : IDLE) :
             r_state == CLEAR ? (w_req_own ? RUN : IDLE) :
             w_run ? (w_kill ? IDLE : (m_done ? FINISH : RUN)) : IDLE;
    gnt0 = r_state != IDLE && !r_own;
    gnt1 = r_state != IDLE && r_own;
    done0 = r_state == FINISH && !r_own;
    done1 = r_state == FINISH && r_own;
    err0 = w_to && !r_own;
    err1 = w_to && r_own;
    m_rst = rst || !w_run;
    m_start = w_run;
    z_stb0 = w_run && !w_kill && !r_own && m_z_stb;
    z_stb1 = w_run && !w_kill && r_own && m_z_stb;
    // a strobe caught in a teardown cycle is swallowed here rather than forwarded
    m_z_ack = w_run && (w_kill ? m_z_stb : (r_own ? z_ack1 : z_ack0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_own <= 1'b0;
      r_ptr <= 1'b0;
      r_cnt <= '0;
      r_jobs <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) r_own <= r_ptr ? req1 : !req0;
      r_cnt <= w_run ? r_cnt + CW'(1) : '0;
      if (r_state == FINISH) r_jobs <= r_jobs + 16'd1;
      if (r_state != IDLE && w_next == IDLE) r_ptr <= !r_own;
    end
  end
endmodule

// File: tb/tb_matmul_job_arbiter.sv
// tb_matmul_job_arbiter: scoreboard bench with a behavioural sequential multiplier
module tb_matmul_job_arbiter;
  localparam int M = 4, DW = 32, IW = 2, TO = 64;
  typedef struct packed {logic [IW-1:0] i; logic [IW-1:0] j; logic [DW-1:0] v;} res_t;
  logic clk = 0, rst = 1, req0 = 0, req1 = 0, t_req0 = 0;
  always #5 clk = ~clk;
  logic gnt0, gnt1, done0, done1, err0, err1, z_stb0, z_stb1, z_ack0, z_ack1, m_rst, m_start, m_z_ack;
  logic [DW-1:0] a_in0, b_in0, a_in1, b_in1, z_out, m_a_in, m_b_in, m_z_out;
  logic [IW-1:0] a_i, a_j, b_i, b_j, z_i, z_j, m_a_i, m_a_j, m_b_i, m_b_j, m_z_i, m_z_j;
  logic m_z_stb, m_done;
  logic [15:0] jobs_done;
  logic [DW-1:0] ma [2][M][M], mb [2][M][M];
  logic [IW-1:0] mi, mj, mk;
  logic [DW-1:0] acc;
  logic [1:0] ph;
  logic t_gnt0, t_gnt1, t_done0, t_done1, t_err0, t_err1, t_stb0, t_stb1, t_m_rst, t_m_start, t_ack;
  logic [DW-1:0] t_z_out, t_ma, t_mb;
  logic [IW-1:0] t_ai, t_aj, t_bi, t_bj, t_zi, t_zj;
  logic [15:0] t_jobs;
  int n_chk = 0, n_err = 0, res_n [2] = '{0, 0}, done_n [2] = '{0, 0}, t_done_n = 0;
  res_t q0 [$], q1 [$];
  int gq [$];
  logic pg0 = 0, pg1 = 0;

  assign a_in0 = ma[0][a_i][a_j];
  assign b_in0 = mb[0][b_i][b_j];
  assign a_in1 = ma[1][a_i][a_j];
  assign b_in1 = mb[1][b_i][b_j];
  assign z_ack0 = z_stb0;
  assign z_ack1 = z_stb1;
  assign m_a_i = mi;
  assign m_a_j = mk;
  assign m_b_i = mk;
  assign m_b_j = mj;

  matmul_job_arbiter u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .a_in0(a_in0), .b_in0(b_in0), .a_in1(a_in1), .b_in1(b_in1),
    .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j), .z_out(z_out), .z_i(z_i), .z_j(z_j),
    .z_stb0(z_stb0), .z_stb1(z_stb1), .z_ack0(z_ack0), .z_ack1(z_ack1),
    .m_rst(m_rst), .m_start(m_start), .m_a_in(m_a_in), .m_b_in(m_b_in),
    .m_a_i(m_a_i), .m_a_j(m_a_j), .m_b_i(m_b_i), .m_b_j(m_b_j),
    .m_z_out(m_z_out), .m_z_i(m_z_i), .m_z_j(m_z_j), .m_z_stb(m_z_stb), .m_z_ack(m_z_ack),
    .m_done(m_done), .jobs_done(jobs_done)
  );

  matmul_job_arbiter #(.TIMEOUT(TO)) u_to (
    .clk(clk), .rst(rst), .req0(t_req0), .req1(1'b0), .gnt0(t_gnt0), .gnt1(t_gnt1),
    .done0(t_done0), .done1(t_done1), .err0(t_err0), .err1(t_err1),
    .a_in0('0), .b_in0('0), .a_in1('0), .b_in1('0),
    .a_i(t_ai), .a_j(t_aj), .b_i(t_bi), .b_j(t_bj), .z_out(t_z_out), .z_i(t_zi), .z_j(t_zj),
    .z_stb0(t_stb0), .z_stb1(t_stb1), .z_ack0(1'b0), .z_ack1(1'b0),
    .m_rst(t_m_rst), .m_start(t_m_start), .m_a_in(t_ma), .m_b_in(t_mb),
    .m_a_i('0), .m_a_j('0), .m_b_i('0), .m_b_j('0),
    .m_z_out('0), .m_z_i('0), .m_z_j('0), .m_z_stb(1'b0), .m_z_ack(t_ack),
    .m_done(1'b0), .jobs_done(t_jobs)
  );

  always @(posedge clk) begin
    if (m_rst) begin
      mi <= '0;
      mj <= '0;
      mk <= '0;
      acc <= '0;
      ph <= 2'd0;
      m_z_stb <= 1'b0;
      m_done <= 1'b0;
      m_z_out <= '0;
      m_z_i <= '0;
      m_z_j <= '0;
    end else if (m_start) begin
      if (ph == 2'd0) begin
        if (mk == IW'(M - 1)) begin
          m_z_out <= acc + m_a_in * m_b_in;
          m_z_i <= mi;
          m_z_j <= mj;
          m_z_stb <= 1'b1;
          acc <= '0;
          mk <= '0;
          ph <= 2'd1;
        end else begin
          acc <= acc + m_a_in * m_b_in;
          mk <= mk + IW'(1);
        end
      end else if (ph == 2'd1 && m_z_ack) begin
        m_z_stb <= 1'b0;
        if (mi == IW'(M - 1) && mj == IW'(M - 1)) begin
          ph <= 2'd2;
          m_done <= 1'b1;
        end else begin
          ph <= 2'd0;
          {mi, mj} <= {mi, mj} + 4'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("stb_route", {z_stb0 & ~(gnt0 & m_start), z_stb1 & ~(gnt1 & m_start)}, 0);
    if (z_stb0) begin
      chk("q0_nonempty", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        chk("res0", {z_i, z_j, z_out}, q0[0]);
        void'(q0.pop_front());
      end
      res_n[0] <= res_n[0] + 1;
    end
    if (z_stb1) begin
      chk("q1_nonempty", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        chk("res1", {z_i, z_j, z_out}, q1[0]);
        void'(q1.pop_front());
      end
      res_n[1] <= res_n[1] + 1;
    end
    done_n[0] <= done_n[0] + int'(done0);
    done_n[1] <= done_n[1] + int'(done1);
    t_done_n <= t_done_n + int'(t_done0);
    if (gnt0 && !pg0) gq.push_back(0);
    if (gnt1 && !pg1) gq.push_back(1);
    pg0 <= gnt0;
    pg1 <= gnt1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input bit ident);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        ma[r][i][j] = ident ? DW'(i == j) : DW'($urandom_range(0, 255));
        mb[r][i][j] = ident ? DW'(i * M + j + 1) : DW'($urandom);
      end
  endtask

  task automatic push(input int r);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < M; k++) s = s + ma[r][i][k] * mb[r][k][j];
        if (r == 0) q0.push_back({IW'(i), IW'(j), s});
        else q1.push_back({IW'(i), IW'(j), s});
      end
  endtask

  task automatic wait_done(input int r);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (r == 0 ? done0 : done1) break;
    end
    chk($sformatf("done%0d_seen", r), k < 400, 1);
  endtask

  task automatic wait_res(input int r, input int n);
    int base, k;
    base = res_n[r];
    for (k = 0; k < 400 && res_n[r] - base < n; k++) @(posedge clk);
    chk("res_wait", res_n[r] - base >= n, 1);
    #1;
  endtask

  initial begin
    int k;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out", {gnt0, gnt1, done0, done1, err0, err1, z_stb0, z_stb1, m_start, m_rst}, 10'b1);
    chk("rst_jobs", jobs_done, 0);
    chk("t_rst_out", {t_gnt0, t_gnt1, t_err0, t_m_start, t_m_rst}, 5'b1);
    tick();
    rst = 0;
    // single job: identity A returns B in order
    load(0, 1);
    push(0);
    req0 = 1;
    @(negedge clk);
    chk("s_gnt_idle", gnt0, 0);
    @(negedge clk);
    chk("s_clear", {gnt0, gnt1, m_rst, m_start}, 4'b1010);
    @(negedge clk);
    chk("s_run", {gnt0, m_rst, m_start}, 3'b101);
    wait_done(0);
    tick();
    req0 = 0;
    @(negedge clk);
    chk("s_gnt_drop", gnt0, 0);
    chk("s_jobs", jobs_done, 1);
    chk("s_res", res_n[0], 16);
    chk("s_q", q0.size(), 0);
    chk("s_no_stb1", res_n[1], 0);
    // contention right after reset
    tick();
    rst = 1;
    tick();
    rst = 0;
    gq.delete();
    load(0, 0);
    load(1, 0);
    push(0);
    push(1);
    req0 = 1;
    req1 = 1;
    wait_done(0);
    tick();
    req0 = 0;
    @(negedge clk);
    chk("c_gnt1_f1", gnt1, 0);
    @(negedge clk);
    chk("c_gnt1_f2", {gnt0, gnt1, m_start}, 3'b010);
    @(negedge clk);
    chk("c_start_f3", {gnt1, m_start}, 2'b11);
    wait_done(1);
    tick();
    req1 = 0;
    @(negedge clk);
    chk("c_jobs", jobs_done, 2);
    chk("c_q", q0.size() + q1.size(), 0);
    chk("c_order", {gq.size(), gq.size() == 2 ? {gq[0], gq[1]} : 64'hx}, {32'd2, 32'd0, 32'd1});
    // fairness with both held over four jobs
    tick();
    gq.delete();
    push(0);
    push(0);
    push(1);
    push(1);
    req0 = 1;
    req1 = 1;
    for (int n = 0; n < 4; n++) wait_done(n % 2);
    tick();
    req0 = 0;
    req1 = 0;
    @(negedge clk);
    chk("f_jobs", jobs_done, 6);
    chk("f_q", q0.size() + q1.size(), 0);
    chk("f_ngrants", gq.size(), 4);
    for (int n = 0; n < 4 && n < gq.size(); n++) chk($sformatf("f_order%0d", n), gq[n], n % 2);
    // abort: requester 1 drops after five results
    tick();
    push(1);
    k = done_n[1];
    req1 = 1;
    wait_res(1, 5);
    req1 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("a_teardown", {gnt1, m_rst, m_start}, 3'b010);
    repeat (3) @(negedge clk);
    chk("a_no_done", done_n[1] - k, 0);
    chk("a_jobs", jobs_done, 6);
    chk("a_left", q1.size(), 11);
    q1.delete();
    load(0, 0);
    push(0);
    tick();
    req0 = 1;
    wait_done(0);
    tick();
    req0 = 0;
    @(negedge clk);
    chk("a_next_jobs", jobs_done, 7);
    chk("a_next_q", q0.size(), 0);
    // timeout on the stalled instance
    tick();
    t_req0 = 1;
    k = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (t_m_start) k++;
      if (t_err0) break;
    end
    chk("t_err_cycle", k, TO);
    chk("t_err1", t_err1, 0);
    @(negedge clk);
    chk("t_teardown", {t_gnt0, t_m_rst, t_m_start, t_done0}, 4'b0100);
    tick();
    t_req0 = 0;
    @(negedge clk);
    chk("t_jobs", t_jobs, 0);
    chk("t_no_done", t_done_n, 0);
    // reset in the middle of a job
    tick();
    load(0, 0);
    push(0);
    req0 = 1;
    wait_res(0, 3);
    rst = 1;
    req0 = 0;
    tick();
    rst = 0;
    @(negedge clk);
    chk("r_out", {gnt0, gnt1, done0, done1, err0, err1, z_stb0, z_stb1, m_start, m_rst}, 10'b1);
    chk("r_jobs", jobs_done, 0);
    q0.delete();
    load(0, 1);
    push(0);
    tick();
    req0 = 1;
    wait_done(0);
    tick();
    req0 = 0;
    @(negedge clk);
    chk("r_next_jobs", jobs_done, 1);
    chk("r_next_q", q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
